// File: rtl/sigma_delta_cic_decimator.sv
// CIC decimator for a 1-bit sigma-delta stream: ORDER integrators at the input rate,
// decimate by DECIM, ORDER combs at the output rate, single-entry valid/ready output.
module sigma_delta_cic_decimator #(
  parameter int ORDER = 3,
  parameter int DECIM = 64,
  localparam int ACC_WIDTH = ORDER * $clog2(DECIM) + 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 enable,
  input  logic                 sigma_delta,
  output logic [ACC_WIDTH-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 overrun,
  output logic                 warm
);

  localparam int CNT_W = $clog2(DECIM);
  localparam int WU_W  = $clog2(ORDER + 2);
  localparam logic [CNT_W-1:0] DEC_LAST = CNT_W'(DECIM - 1);
  localparam logic [WU_W-1:0]  WU_DONE  = WU_W'(ORDER + 1);

  logic [ACC_WIDTH-1:0] integ_q [ORDER];
  logic [ACC_WIDTH-1:0] integ_d [ORDER];
  logic [ACC_WIDTH-1:0] dly_q   [ORDER];
  logic [ACC_WIDTH-1:0] dly_d   [ORDER];
  logic [ACC_WIDTH-1:0] comb_in [ORDER];
  logic [ACC_WIDTH-1:0] comb_res;

  logic [CNT_W-1:0]     dec_cnt_q, dec_cnt_d;
  logic [WU_W-1:0]      warmup_q, warmup_d;
  logic [ACC_WIDTH-1:0] tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic                 overrun_q, overrun_d;
  logic                 strobe;

  assign strobe = (dec_cnt_q == DEC_LAST);

  // All arithmetic wraps modulo 2^ACC_WIDTH; the comb differences undo the integrator wrap.
  always_comb begin
    integ_d[0] = integ_q[0] + ACC_WIDTH'(sigma_delta);
    for (int k = 1; k < ORDER; k++) begin
      integ_d[k] = integ_q[k] + integ_q[k-1];
    end
    if (!enable) begin
      for (int k = 0; k < ORDER; k++) begin
        integ_d[k] = '0;
      end
    end
  end

  always_comb begin : comb_chain
    logic [ACC_WIDTH-1:0] stage_v;
    stage_v = integ_q[ORDER-1];
    for (int k = 0; k < ORDER; k++) begin
      comb_in[k] = stage_v;
      stage_v    = stage_v - dly_q[k];
    end
    comb_res = stage_v;
  end

  always_comb begin
    dec_cnt_d = dec_cnt_q;
    warmup_d  = warmup_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    overrun_d = overrun_q;
    for (int k = 0; k < ORDER; k++) begin
      dly_d[k] = dly_q[k];
    end

    if (!enable) begin
      dec_cnt_d = '0;
      warmup_d  = '0;
      tdata_d   = '0;
      tvalid_d  = 1'b0;
      overrun_d = 1'b0;
      for (int k = 0; k < ORDER; k++) begin
        dly_d[k] = '0;
      end
    end else begin
      dec_cnt_d = strobe ? '0 : dec_cnt_q + 1'b1;
      if (strobe) begin
        for (int k = 0; k < ORDER; k++) begin
          dly_d[k] = comb_in[k];
        end
        // A pending unaccepted sample is replaced; a same-edge handshake consumes it first.
        if (warmup_q == WU_DONE) begin
          tdata_d  = comb_res;
          tvalid_d = 1'b1;
          if (tvalid_q && !m_tready) begin
            overrun_d = 1'b1;
          end
        end else begin
          warmup_d = warmup_q + 1'b1;
        end
      end else if (tvalid_q && m_tready) begin
        tvalid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < ORDER; k++) begin
        integ_q[k] <= '0;
        dly_q[k]   <= '0;
      end
      dec_cnt_q <= '0;
      warmup_q  <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      for (int k = 0; k < ORDER; k++) begin
        integ_q[k] <= integ_d[k];
        dly_q[k]   <= dly_d[k];
      end
      dec_cnt_q <= dec_cnt_d;
      warmup_q  <= warmup_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      overrun_q <= overrun_d;
    end
  end

  assign m_tdata  = tdata_q;
  assign m_tvalid = tvalid_q;
  assign overrun  = overrun_q;
  assign warm     = (warmup_q == WU_DONE);

endmodule

// File: tb/tb_sigma_delta_cic_decimator.sv
// Directed bench for sigma_delta_cic_decimator (ORDER=3, DECIM=64): expected samples are
// queued by the stimulus and checked by a handshake monitor; flags are checked inline.
module tb_sigma_delta_cic_decimator;

  localparam int ORDER = 3;
  localparam int DECIM = 64;
  localparam int ACC_WIDTH = ORDER * $clog2(DECIM) + 1;
  localparam logic [ACC_WIDTH-1:0] FULL = 19'd262144;
  localparam logic [ACC_WIDTH-1:0] HALF = 19'd131072;
  localparam logic [ACC_WIDTH-1:0] ZERO = 19'd0;

  logic                 aclk = 1'b0;
  logic                 aresetn = 1'b0;
  logic                 enable = 1'b0;
  logic                 sigma_delta = 1'b0;
  logic                 m_tready = 1'b0;
  logic                 alt_mode = 1'b0;
  logic [ACC_WIDTH-1:0] m_tdata;
  logic                 m_tvalid;
  logic                 overrun;
  logic                 warm;

  int n_cmp = 0;
  int n_bad = 0;
  logic [ACC_WIDTH-1:0] exp_q[$];

  always #5 aclk = ~aclk;

  sigma_delta_cic_decimator #(.ORDER(ORDER), .DECIM(DECIM)) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .enable(enable),
    .sigma_delta(sigma_delta),
    .m_tdata(m_tdata),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .overrun(overrun),
    .warm(warm)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic edges(input int k);
    repeat (k) @(posedge aclk);
    #1;
  endtask

  task automatic start_run(input logic sd, input logic alt, input logic rdy);
    sigma_delta = sd;
    alt_mode    = alt;
    m_tready    = rdy;
    enable      = 1'b1;
  endtask

  task automatic drop_enable(input string tag);
    enable   = 1'b0;
    alt_mode = 1'b0;
    edges(1);
    chk({tag, "_clr_tdata"}, 32'(m_tdata), 32'(ZERO));
    chk({tag, "_clr_tvalid"}, 32'(m_tvalid), 0);
    chk({tag, "_clr_overrun"}, 32'(overrun), 0);
    chk({tag, "_clr_warm"}, 32'(warm), 0);
  endtask

  task automatic warm_check(input string tag);
    edges(255);
    chk({tag, "_warm_early"}, 32'(warm), 0);
    edges(1);
    chk({tag, "_warm_edge256"}, 32'(warm), 1);
    chk({tag, "_tvalid_at_warm"}, 32'(m_tvalid), 0);
  endtask

  // Alternating 1010... source for the half-scale case.
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (alt_mode) sigma_delta = ~sigma_delta;
    end
  end

  // Monitor: every accepted sample must match the head of the expectation queue.
  initial begin
    forever begin
      @(negedge aclk);
      if (aresetn && enable && m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_sample: got %0d, expected no sample (t=%0t)", m_tdata, $time);
        end else begin
          chk("sample", 32'(m_tdata), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #2;
    chk("rst_tdata", 32'(m_tdata), 0);
    chk("rst_tvalid", 32'(m_tvalid), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_warm", 32'(warm), 0);
    #20 aresetn = 1'b1;
    edges(1);

    // Constant 1: full scale every 64 cycles after warm-up.
    start_run(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) exp_q.push_back(FULL);
    warm_check("ones");
    edges(64);
    chk("ones_first_valid", 32'(m_tvalid), 1);
    chk("ones_first_tdata", 32'(m_tdata), 32'(FULL));
    edges(193);
    chk("ones_tvalid_low", 32'(m_tvalid), 0);
    drop_enable("ones");

    // Constant 0.
    start_run(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) exp_q.push_back(ZERO);
    edges(385);
    chk("zeros_overrun", 32'(overrun), 0);
    drop_enable("zeros");

    // 1010... gives half scale.
    start_run(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) exp_q.push_back(HALF);
    edges(385);
    drop_enable("alt");

    // Handshake coinciding with a strobe: no overrun, valid stays high.
    start_run(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) exp_q.push_back(FULL);
    edges(320);
    chk("sim_valid_s5", 32'(m_tvalid), 1);
    edges(63);
    m_tready = 1'b1;
    edges(1);
    chk("sim_valid_s6", 32'(m_tvalid), 1);
    chk("sim_overrun_s6", 32'(overrun), 0);
    edges(1);
    chk("sim_valid_after", 32'(m_tvalid), 0);
    chk("sim_overrun_after", 32'(overrun), 0);
    drop_enable("sim");

    // Backpressure across two strobes: sticky overrun.
    start_run(1'b1, 1'b0, 1'b0);
    edges(320);
    chk("bp_valid_s5", 32'(m_tvalid), 1);
    chk("bp_overrun_s5", 32'(overrun), 0);
    edges(64);
    chk("bp_overrun_s6", 32'(overrun), 1);
    chk("bp_valid_s6", 32'(m_tvalid), 1);
    chk("bp_tdata_s6", 32'(m_tdata), 32'(FULL));
    exp_q.push_back(FULL);
    m_tready = 1'b1;
    edges(1);
    chk("bp_valid_drop", 32'(m_tvalid), 0);
    chk("bp_overrun_sticky", 32'(overrun), 1);
    edges(10);
    chk("bp_overrun_still", 32'(overrun), 1);
    chk("bp_tdata_hold", 32'(m_tdata), 32'(FULL));
    drop_enable("bp");

    // Re-enable after the one-cycle drop, then asynchronous reset while a sample is pending.
    start_run(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) exp_q.push_back(FULL);
    warm_check("reen");
    edges(129);
    m_tready = 1'b0;
    edges(63);
    chk("ar_valid_before", 32'(m_tvalid), 1);
    #2;
    aresetn = 1'b0;
    enable  = 1'b0;
    #1;
    chk("ar_tvalid", 32'(m_tvalid), 0);
    chk("ar_tdata", 32'(m_tdata), 0);
    chk("ar_warm", 32'(warm), 0);
    #3;
    aresetn = 1'b1;
    edges(1);
    start_run(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) exp_q.push_back(FULL);
    warm_check("post_rst");
    edges(129);
    drop_enable("post_rst");

    edges(5);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sigma_delta_cic_decimator.md
Name: sigma_delta_cic_decimator

Overview:
- Downstream consumer of the sigma-delta modulator's 1-bit `sigma_delta` stream.
- Recovers a multi-bit sample with an ORDER-stage CIC decimation filter (integrators, decimate by DECIM, combs).
- Delivers samples on a valid/ready output with single-entry buffering and a sticky overrun flag.
- Used in loopback verification of the modulator and as the on-chip sigma-delta ADC back end.

Parameters:
ORDER, 3, number of integrator and comb stages; range 1..5.
DECIM, 64, decimation ratio; power of 2, greater than ORDER, at least 4.
ACC_WIDTH (localparam), ORDER*log2(DECIM)+1, width of the integrators, combs and output.

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
enable  in  1  filter run enable; low means synchronous clear of all state
sigma_delta  in  1  modulator bit stream; 1 counts as 1, 0 counts as 0
m_tdata  out  ACC_WIDTH  unsigned decimated sample
m_tvalid  out  1  sample valid
m_tready  in  1  consumer ready
overrun  out  1  sticky: a sample was overwritten before it was accepted
warm  out  1  warm-up complete; output samples are now valid

Behaviour:
- Reset (aresetn low, asynchronous): all integrators, comb delays, dec_cnt and warmup_cnt go to 0. Outputs m_tdata=0, m_tvalid=0, overrun=0, warm=0.
- enable low: on each edge, the same clear as reset. enable has priority over every other event.
- Integrators:
  - Stage 1 adds the zero-extended `sigma_delta` bit each enabled cycle; stage k adds the registered stage k-1 output.
  - Each stage is registered, so the integrator chain has ORDER cycles of latency.
  - Modulo-2^ACC_WIDTH wrap-around is required and intended; no saturation.
- Decimation counter dec_cnt:
  - Counts 0..DECIM-1 while enabled, wrapping to 0.
  - A strobe occurs on the cycle where dec_cnt==DECIM-1.
- Comb chain:
  - Evaluated on the strobe edge from the last integrator value.
  - Stage k output = in_k − delay_k, modulo 2^ACC_WIDTH.
  - delay_k <= in_k on the strobe edge only. Combs are combinational between strobes, registered into the output.
- Warm-up:
  - warmup_cnt counts strobes up to ORDER+1 and saturates there.
  - While warmup_cnt < ORDER+1, comb results are computed (delays update) but not presented.
  - warm goes high on the edge where warmup_cnt reaches ORDER+1. The first presented sample is the comb result on the strobe following that edge.
- Output register:
  - On a presentable strobe: m_tdata <= comb result and m_tvalid <= 1.
  - If m_tvalid=1 and m_tready=0 on that edge, the old sample is overwritten and overrun <= 1.
  - Handshake: m_tvalid=1 and m_tready=1 on an edge with no strobe gives m_tvalid <= 0.
  - Simultaneous strobe and handshake: the old sample is accepted, the new one is loaded, m_tvalid stays 1, no overrun.
  - m_tdata holds its value when m_tvalid is 0.
- overrun clears only on reset or enable low.
- Steady state with constant input p (0 or 1): m_tdata = p·DECIM^ORDER. The full-scale value DECIM^ORDER = 2^(ACC_WIDTH−1) fits exactly.
- Throughput: one sample per DECIM cycles.
- m_tready is ignored while m_tvalid=0.

Test Plan:
- ORDER=3, DECIM=64, enable=1, sigma_delta held at 1 → warm rises after 4 strobes (edge 256); the first sample after warm, and every one after, is m_tdata=0x40000 (262144), one per 64 cycles.
- sigma_delta held at 0 → every presented sample is 0. Asserting enable with a 1010… pattern → warmed samples equal 131072.
- Backpressure: m_tready=0 across two presentable strobes → overrun=1 and m_tdata holds the newer sample. Raising m_tready then gives one handshake, m_tvalid drops, overrun stays 1.
- Handshake on the same edge as a strobe → m_tvalid stays 1, new data loaded, overrun stays 0.
- Drop enable mid-frame for 1 cycle → next edge all outputs 0, warm=0, overrun=0. After re-enable with constant 1, the first valid sample is again 262144 after 4 strobes.
- Assert aresetn low asynchronously mid-cycle while m_tvalid=1 → m_tvalid, m_tdata and warm go to 0 immediately, without waiting for a clock edge. After release, the same sequence as the all-ones case is reproduced exactly.
